// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the round-robin RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Index width that stays at least one bit wide for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_arb_rr_arb.sv
// Combinational rotating-priority arbiter: the search begins at ptr_i and wraps.
module rr_arb
    import ram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    // Walk from the lowest to the highest priority so the last hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one ram_dp port; registered command stage and
// a {valid,id} tag pipeline that lines responses up with the RAM read latency.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 64,
    parameter int D_DEPTH = 32,
    parameter int REG_OUT = 1,
    localparam int AW     = $clog2(D_DEPTH),
    localparam int IW     = clog2_min1(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ-1:0]              req_wr_i,
    input  logic [N_REQ-1:0][AW-1:0]      req_addr_i,
    input  logic [N_REQ-1:0][D_WIDTH-1:0] req_data_i,
    output logic                          rsp_valid_o,
    output logic [IW-1:0]                 rsp_id_o,
    output logic [D_WIDTH-1:0]            rsp_data_o,
    output logic                          ram_wr_en_o,
    output logic [AW-1:0]                 ram_wr_addr_o,
    output logic [D_WIDTH-1:0]            ram_wr_data_o,
    output logic                          ram_rd_en_o,
    output logic [AW-1:0]                 ram_rd_addr_o,
    input  logic [D_WIDTH-1:0]            ram_rd_data_i
);

    logic [N_REQ-1:0]   gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    op_e                gnt_op;
    logic [AW-1:0]      gnt_addr;
    logic [D_WIDTH-1:0] gnt_data;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic               wr_en_q, rd_en_q;
    logic [AW-1:0]      addr_q;
    logic [D_WIDTH-1:0] data_q;
    logic               tag_vld_q [REG_OUT+1];
    logic [IW-1:0]      tag_id_q  [REG_OUT+1];

    rr_arb #(.N(N_REQ), .IW(IW)) u_rr_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign gnt_op   = op_e'(req_wr_i[gnt_idx]);
    assign gnt_addr = req_addr_i[gnt_idx];
    assign gnt_data = req_data_i[gnt_idx];

    // The RAM port takes a command every cycle, so a grant is also the accept.
    assign req_ready_o = gnt & {N_REQ{rst_n_i}};

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q   <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int k = 0; k <= REG_OUT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_id_q[k]  <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            wr_en_q <= gnt_any && (gnt_op == OP_WR);
            rd_en_q <= gnt_any && (gnt_op == OP_RD);
            if (gnt_any) begin
                addr_q <= gnt_addr;
            end
            if (gnt_any && (gnt_op == OP_WR)) begin
                data_q <= gnt_data;
            end
            tag_vld_q[0] <= gnt_any && (gnt_op == OP_RD);
            tag_id_q[0]  <= gnt_idx;
            for (int k = REG_OUT; k >= 1; k--) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    assign ram_wr_en_o   = wr_en_q;
    assign ram_wr_addr_o = addr_q;
    assign ram_wr_data_o = data_q;
    assign ram_rd_en_o   = rd_en_q;
    assign ram_rd_addr_o = addr_q;

    // Gate data with the tag so the response bus reads zero when idle and in reset.
    assign rsp_valid_o = tag_vld_q[REG_OUT];
    assign rsp_id_o    = tag_id_q[REG_OUT];
    assign rsp_data_o  = tag_vld_q[REG_OUT] ? ram_rd_data_i : '0;

    always @(posedge clk_i) begin : addr_range_check
        if (rst_n_i && gnt_any) begin
            assert (32'(gnt_addr) < 32'(D_DEPTH));
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Randomized bench for ram_arb: ram_dp model on the RAM port, scoreboard memory
// and expected-response queue derived from the round-robin and latency rules.
module tb_ram_arb;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int DD = 32;
    localparam int RO = 1;
    localparam int AW = $clog2(DD);
    localparam int IW = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0]           req_wr;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][DW-1:0]   req_data;
    logic                   rsp_valid;
    logic [IW-1:0]          rsp_id;
    logic [DW-1:0]          rsp_data;
    logic                   ram_wr_en, ram_rd_en;
    logic [AW-1:0]          ram_wr_addr, ram_rd_addr;
    logic [DW-1:0]          ram_wr_data, ram_rd_data;

    ram_arb #(.N_REQ(N), .D_WIDTH(DW), .D_DEPTH(DD), .REG_OUT(RO)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_wr_i      (req_wr),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_id_o      (rsp_id),
        .rsp_data_o    (rsp_data),
        .ram_wr_en_o   (ram_wr_en),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_data_o (ram_wr_data),
        .ram_rd_en_o   (ram_rd_en),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ram_dp port model: synchronous write, optional registered read
    logic [DW-1:0] ram_mem [DD];
    logic [DW-1:0] ram_rd_q;
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_q <= ram_mem[ram_rd_addr];
    end
    assign ram_rd_data = (RO == 1) ? ram_rd_q : ram_mem[ram_rd_addr];

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          due;
    } rsp_t;

    rsp_t          exp_q [$];
    logic [DW-1:0] sb_mem [DD];
    int            model_ptr;
    int            cyc;
    int            last_gnt;
    logic [N-1:0]  prev_gnt;
    logic          pw_en, pr_en;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    int            n_checks;
    int            n_errors;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_gnt;
        logic         exp_v;
        int           pidx;
        @(negedge clk);
        exp_gnt = '0;
        for (int k = 0; k < N; k++) begin
            pidx = (model_ptr + k) % N;
            if (exp_gnt == '0 && req_valid[pidx]) exp_gnt[pidx] = 1'b1;
        end
        check_eq("ready", DW'(req_ready), DW'(exp_gnt));
        last_gnt = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) last_gnt = i;

        check_eq("ram_wr_en", DW'(ram_wr_en), DW'(pw_en));
        check_eq("ram_rd_en", DW'(ram_rd_en), DW'(pr_en));
        if (pw_en || pr_en) begin
            check_eq("ram_wr_addr", DW'(ram_wr_addr), DW'(p_addr));
            check_eq("ram_rd_addr", DW'(ram_rd_addr), DW'(p_addr));
        end
        if (pw_en) check_eq("ram_wr_data", ram_wr_data, p_data);

        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check_eq("rsp_valid", DW'(rsp_valid), DW'(exp_v));
        if (exp_v) begin
            if (rsp_valid) begin
                check_eq("rsp_id", DW'(rsp_id), DW'(exp_q[0].id));
                check_eq("rsp_data", rsp_data, exp_q[0].data);
                $display("cyc=%0d rsp id=%0d data=%h", cyc, rsp_id, rsp_data);
            end
            void'(exp_q.pop_front());
        end

        pw_en = 1'b0;
        pr_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) begin
                p_addr = req_addr[i];
                if (req_wr[i]) begin
                    pw_en = 1'b1;
                    p_data = req_data[i];
                    sb_mem[req_addr[i]] = req_data[i];
                end else begin
                    pr_en = 1'b1;
                    exp_q.push_back('{i, sb_mem[req_addr[i]], cyc + RO + 1});
                end
                model_ptr = (i + 1) % N;
                $display("cyc=%0d req=%0d %s addr=%0d", cyc, i, req_wr[i] ? "WR" : "RD", req_addr[i]);
            end
        end
        prev_gnt = exp_gnt;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int i, input logic v, input logic wr, input int addr, input logic [DW-1:0] data);
        req_valid[i] = v;
        req_wr[i]    = wr;
        req_addr[i]  = AW'(addr);
        req_data[i]  = data;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, DW'(req_ready), '0);
        check_eq({tag, "_wr_en"}, DW'(ram_wr_en), '0);
        check_eq({tag, "_rd_en"}, DW'(ram_rd_en), '0);
        check_eq({tag, "_addr"}, DW'({ram_wr_addr, ram_rd_addr}), '0);
        check_eq({tag, "_wdata"}, ram_wr_data, '0);
        check_eq({tag, "_rsp"}, DW'({rsp_valid, rsp_id}), '0);
        check_eq({tag, "_rdata"}, rsp_data, '0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_ptr = 0;
        pw_en = 1'b0;
        pr_en = 1'b0;
        prev_gnt = '0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        p_addr = '0;
        p_data = '0;
        model_reset();
        rst_n = 1'b0;
        req_valid = '1;
        req_wr = '0;
        req_addr = '0;
        req_data = '0;

        // reset state with requests pending
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst0");
        req_valid = '0;
        rst_n = 1'b1;

        // preload every address so later reads compare against known data
        for (int a = 0; a < DD; a++) begin
            drive(a % N, 1'b1, 1'b1, a, {$urandom, $urandom});
            step();
            req_valid = '0;
        end

        // req 0: write 0xA5 @3 then read @3
        drive(0, 1'b1, 1'b1, 3, 64'hA5);
        step();
        drive(0, 1'b1, 1'b0, 3, '0);
        step();
        req_valid = '0;
        repeat (3) step();

        // all four reading continuously: rotation from current ptr
        first = model_ptr;
        req_valid = '1;
        req_wr = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            check_eq("t3_order", DW'(last_gnt), DW'((first + k) % N));
            for (int i = 0; i < N; i++) if (prev_gnt[i]) req_addr[i] = AW'($urandom % DD);
        end
        req_valid = '0;
        repeat (3) step();

        // move ptr to 2, then req 1 and 3 contend: 3 first, 1 held then granted
        drive(1, 1'b1, 1'b0, 5, '0);
        step();
        drive(1, 1'b1, 1'b1, 7, 64'h1111_2222_3333_4444);
        drive(3, 1'b1, 1'b0, 7, '0);
        step();
        check_eq("t4_first", DW'(last_gnt), DW'(3));
        req_valid[3] = 1'b0;
        step();
        check_eq("t4_second", DW'(last_gnt), DW'(1));
        req_valid = '0;
        repeat (3) step();

        // write all-ones @31 from req 2, read it from req 0 on the next cycle
        drive(2, 1'b1, 1'b1, DD - 1, '1);
        step();
        req_valid[2] = 1'b0;
        drive(0, 1'b1, 1'b0, DD - 1, '0);
        step();
        req_valid = '0;
        repeat (3) step();

        // reset asserted in the middle of a read burst
        req_valid = '1;
        req_wr = '0;
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst1");
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        repeat (5) step();

        // random traffic, requests held until granted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || prev_gnt[i]) begin
                    req_valid[i] = ($urandom % 10) < 6;
                    req_wr[i]    = $urandom % 2;
                    req_addr[i]  = AW'($urandom % DD);
                    req_data[i]  = {$urandom, $urandom};
                end
            end
            step();
        end
        req_valid = '0;
        repeat (4) step();
        check_eq("drained", DW'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
